sram_copy_ctrl: RTL and testbench

SRAM_COPY_CTRL -- requirements
Module: sram_copy_ctrl

---
 rtl/sram_copy_ctrl_pkg.sv | 16 +
 rtl/sram_copy_fifo.sv | 66 ++++++
 rtl/sram_copy_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sram_copy_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_copy_ctrl_pkg.sv
// Shared definitions for the SRAM copy controller: default SRAM geometry
// and the copy engine state encoding.
package sram_ctrl_pkg;

    // Default SRAM word address width and word width.
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    // Copy engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sram_copy_fifo.sv
// Two-entry FIFO that holds copy read data while port A is owned by the host.
// A push arriving in the same cycle as a pop of the last entry is accepted.
module sram_copy_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    // Pointer, occupancy and storage next-state; a full FIFO only takes a push when it also pops.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_copy_ctrl.sv
// SRAM copy controller. Copies len words from src to dst using port B for
// reads and port A for writes, while a host shares port A for single-word
// accesses. The host normally wins port A; after STARVE_MAX consecutive
// cycles of blocked copy data the copy engine takes one write slot.
//
// Handshake: start is a level sampled only in IDLE (accepted when seen there);
// host_req is granted combinationally via host_gnt and the access happens in
// that same cycle; host_rvalid follows a granted read by exactly one cycle.
module sram_copy_ctrl
    import sram_ctrl_pkg::state_e;
    import sram_ctrl_pkg::IDLE;
    import sram_ctrl_pkg::RUN;
    import sram_ctrl_pkg::DONE;
#(
    parameter int ADDR_W     = sram_ctrl_pkg::ADDR_W,
    parameter int DATA_W     = sram_ctrl_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // copy command
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    // host port
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    // SRAM master side
    output logic              port_a_we,
    output logic [ADDR_W-1:0] port_a_addr,
    output logic [DATA_W-1:0] port_a_wdata,
    input  logic [DATA_W-1:0] port_a_rdata,
    output logic [ADDR_W-1:0] port_b_addr,
    input  logic [DATA_W-1:0] port_b_rdata,
    // debug
    output state_e            dbg_state_o
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   wr_cnt_inc;
    logic              inflight_q, inflight_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              host_rvalid_q, host_rvalid_d;

    logic              host_blocked;
    logic              copy_pending;
    logic              host_gnt_int;
    logic              copy_wr;
    logic              from_fifo;
    logic [DATA_W-1:0] copy_wdata;
    logic              rd_issue;
    logic [1:0]        occupancy;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [1:0]        fifo_count;

    sram_copy_fifo #(
        .W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (port_b_rdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign wr_cnt_inc = wr_cnt_q + 1'b1;
    assign occupancy  = fifo_count + {1'b0, inflight_q};

    // Port A arbitration, read issue and FIFO control; all gated off during reset.
    always_comb begin
        host_blocked = (starve_q == STARVE_SAT);
        // Copy data is waiting when buffered or returning from port B this cycle.
        copy_pending = (state_q == RUN) && ((fifo_count != 2'd0) || inflight_q);
        host_gnt_int = host_req && !host_blocked && !rst;
        copy_wr      = copy_pending && !host_gnt_int && !rst;
        from_fifo    = (fifo_count != 2'd0);
        copy_wdata   = from_fifo ? fifo_rdata : port_b_rdata;
        fifo_pop     = copy_wr && from_fifo;
        // Returning data goes to the FIFO unless it bypasses straight to port A.
        fifo_push    = inflight_q && !rst && !(copy_wr && !from_fifo);
        rd_issue     = (state_q == RUN) && (rd_cnt_q < len_q) && (occupancy < 2'd2) && !rst;
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        inflight_d    = 1'b0;
        starve_d      = starve_q;
        host_rvalid_d = host_gnt_int && !host_we;

        // Starvation counter: reset by a copy write, counts host-held cycles with data waiting.
        if (copy_wr) begin
            starve_d = '0;
        end else if (copy_pending && host_gnt_int && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    len_d    = len;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    starve_d = '0;
                    state_d  = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                inflight_d = rd_issue;
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (copy_wr) begin
                    wr_cnt_d = wr_cnt_inc;
                    if (wr_cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            inflight_q    <= 1'b0;
            starve_q      <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            inflight_q    <= inflight_d;
            starve_q      <= starve_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Output drive: port A mux, port B address and status, all quiet during reset.
    always_comb begin
        port_a_we    = 1'b0;
        port_a_addr  = '0;
        port_a_wdata = '0;
        port_b_addr  = '0;
        if (host_gnt_int) begin
            port_a_we    = host_we;
            port_a_addr  = host_addr;
            port_a_wdata = host_we ? host_wdata : '0;
        end else if (copy_wr) begin
            port_a_we    = 1'b1;
            port_a_addr  = dst_q + wr_cnt_q[ADDR_W-1:0];
            port_a_wdata = copy_wdata;
        end
        if (rd_issue) begin
            port_b_addr = src_q + rd_cnt_q[ADDR_W-1:0];
        end
        host_gnt    = host_gnt_int;
        host_rvalid = host_rvalid_q && !rst;
        host_rdata  = (host_rvalid_q && !rst) ? port_a_rdata : '0;
        busy        = (state_q == RUN) && !rst;
        done        = (state_q == DONE) && !rst;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_sram_copy_ctrl.sv
// Bench for sram_copy_ctrl: behavioural dual-port SRAM, copy-write scoreboard
// and one task per scenario.
module tb_sram_copy_ctrl;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          port_a_we;
  logic [AW-1:0] port_a_addr;
  logic [DW-1:0] port_a_wdata;
  logic [DW-1:0] port_a_rdata = '0;
  logic [AW-1:0] port_b_addr;
  logic [DW-1:0] port_b_rdata = '0;
  logic [1:0]    dbg_state;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sram_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .port_a_we(port_a_we), .port_a_addr(port_a_addr), .port_a_wdata(port_a_wdata),
    .port_a_rdata(port_a_rdata), .port_b_addr(port_b_addr), .port_b_rdata(port_b_rdata),
    .dbg_state_o(dbg_state)
  );

  // Dual-port SRAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    port_a_rdata <= mem[port_a_addr];
    port_b_rdata <= mem[port_b_addr];
    if (port_a_we) mem[port_a_addr] = port_a_wdata;
  end

  // ---------------- scoreboard ----------------
  // Every port A write without host grant is a copy write and must match the queue head.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!rst && port_a_we && !host_gnt) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL copy_write_unexpected: got addr %0h data %0h, expected no write", port_a_addr, port_a_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({port_a_addr, port_a_wdata} !== e) begin
          errors++;
          $display("FAIL copy_write: got addr %0h data %0h, expected addr %0h data %0h",
                   port_a_addr, port_a_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] sa, da;
    for (int k = 0; k < n; k++) begin
      sa = s + AW'(k);
      da = d + AW'(k);
      exp_q.push_back({da, mem[sa]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; src_addr = 15'h7; dst_addr = 15'h9; len = 16'd5;
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h123; host_wdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt: got %b expected 0", host_gnt); end
    checks++; if (port_a_we !== 1'b0) begin errors++; $display("FAIL reset_port_a_we: got %b expected 0", port_a_we); end
    checks++; if (port_a_addr !== '0) begin errors++; $display("FAIL reset_port_a_addr: got %0h expected 0", port_a_addr); end
    checks++; if (port_b_addr !== '0) begin errors++; $display("FAIL reset_port_b_addr: got %0h expected 0", port_b_addr); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_host_rvalid: got %b expected 0", host_rvalid); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; host_req = 1'b0; len = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  // Uncontended copy: checks read addresses, write timing, busy window and done cycle.
  task automatic run_uncontended(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    int wr_seen;
    bit got_done;
    logic [AW-1:0] exp_b;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = (AW+1)'(n);
    push_expected(s, d, n);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cyc0_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    wr_seen = 0; got_done = 1'b0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c <= n + 1)) begin errors++; $display("FAIL busy_window: cycle %0d got %b expected %b", c, busy, (c <= n + 1)); end
      if (c <= n) begin
        exp_b = s + AW'(c - 1);
        checks++;
        if (port_b_addr !== exp_b) begin errors++; $display("FAIL read_addr: cycle %0d got %0h expected %0h", c, port_b_addr, exp_b); end
      end
      if (port_a_we) begin
        checks++;
        if (c != wr_seen + 2) begin errors++; $display("FAIL write_cycle: write %0d got cycle %0d expected %0d", wr_seen, c, wr_seen + 2); end
        wr_seen++;
      end
      if (done) begin
        got_done = 1'b1;
        checks++;
        if (c != n + 2) begin errors++; $display("FAIL done_cycle: got %0d expected %0d", c, n + 2); end
      end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL done_timeout: got no done expected done at cycle %0d", n + 2); end
    checks++; if (wr_seen != n) begin errors++; $display("FAIL write_count: got %0d expected %0d", wr_seen, n); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_basic_copy();
    run_uncontended(15'h0010, 15'h0100, 4);
  endtask

  task automatic test_wrap();
    run_uncontended(15'h7FFE, 15'h7FFF, 3);
  endtask

  task automatic test_len_zero();
    @(posedge clk); #1;
    start = 1'b1; src_addr = 15'h0040; dst_addr = 15'h0050; len = '0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== (c == 1)) begin errors++; $display("FAIL len0_done: cycle %0d got %b expected %b", c, done, (c == 1)); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: cycle %0d got %b expected 0", c, busy); end
      checks++;
      if (port_a_we !== 1'b0 || port_b_addr !== '0) begin
        errors++; $display("FAIL len0_access: cycle %0d got we %b b_addr %0h expected 0 0", c, port_a_we, port_b_addr);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_host_read();
    logic [DW-1:0] exp_d;
    @(posedge clk); #1;
    exp_d = mem[15'h0020];
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0020;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hrd_gnt: got %b expected 1", host_gnt); end
    checks++; if (port_a_addr !== 15'h0020 || port_a_we !== 1'b0) begin
      errors++; $display("FAIL hrd_port: got addr %0h we %b expected 20 0", port_a_addr, port_a_we);
    end
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL hrd_rvalid: got %b expected 1", host_rvalid); end
    checks++; if (host_rdata !== exp_d) begin errors++; $display("FAIL hrd_rdata: got %0h expected %0h", host_rdata, exp_d); end
    @(negedge clk);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hrd_rvalid_pulse: got %b expected 0", host_rvalid); end
  endtask

  // Host writes every cycle; copy writes land at cycles 6 + 5k, done at 42.
  task automatic test_host_contention();
    int wr_seen;
    bit got_done;
    bit wr_cyc;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 15'h0200; dst_addr = 15'h0300; len = 16'd8;
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h5000; host_wdata = 16'hBEEF;
    push_expected(15'h0200, 15'h0300, 8);
    @(posedge clk); #1;
    start = 1'b0;
    wr_seen = 0; got_done = 1'b0;
    for (int c = 1; c <= 300 && !got_done; c++) begin
      @(negedge clk);
      wr_cyc = (c >= 6) && (c <= 41) && (((c - 6) % 5) == 0);
      checks++;
      if (host_gnt !== !wr_cyc) begin errors++; $display("FAIL arb_gnt: cycle %0d got %b expected %b", c, host_gnt, !wr_cyc); end
      if (host_gnt) begin
        checks++;
        if (port_a_addr !== 15'h5000 || port_a_we !== 1'b1) begin
          errors++; $display("FAIL arb_host_access: cycle %0d got addr %0h we %b expected 5000 1", c, port_a_addr, port_a_we);
        end
      end else if (port_a_we) begin
        checks++;
        if (c != 6 + 5 * wr_seen) begin errors++; $display("FAIL arb_write_cycle: write %0d got %0d expected %0d", wr_seen, c, 6 + 5 * wr_seen); end
        wr_seen++;
      end
      if (done) begin
        got_done = 1'b1;
        checks++;
        if (c != 42) begin errors++; $display("FAIL arb_done_cycle: got %0d expected 42", c); end
      end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL arb_timeout: got no done expected done at 42"); end
    checks++; if (wr_seen != 8) begin errors++; $display("FAIL arb_write_count: got %0d expected 8", wr_seen); end
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    start = 1'b1; src_addr = 15'h0400; dst_addr = 15'h0500; len = 16'd10;
    push_expected(15'h0400, 15'h0500, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0033;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_status: got busy %b done %b expected 0 0", busy, done); end
    checks++; if (port_a_we !== 1'b0 || host_gnt !== 1'b0) begin errors++; $display("FAIL abort_port_a: got we %b gnt %b expected 0 0", port_a_we, host_gnt); end
    checks++; if (port_b_addr !== '0) begin errors++; $display("FAIL abort_port_b: got %0h expected 0", port_b_addr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_first_write: got %0d pending expected 0", exp_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || port_a_we !== 1'b0 || port_b_addr !== '0) begin
        errors++; $display("FAIL abort_quiet: cycle %0d got busy %b done %b we %b b_addr %0h expected 0 0 0 0",
                            c, busy, done, port_a_we, port_b_addr);
      end
    end
    run_uncontended(15'h0600, 15'h0700, 5);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] s;
    int n;
    for (int i = 0; i < 3; i++) begin
      s = AW'($urandom_range(0, 32'h1FFF));
      n = $urandom_range(1, 6);
      run_uncontended(s, s + 15'h2000, n);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_wrap();
    test_host_read();
    test_host_contention();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
